fetch_queue: RTL and testbench

Parametrised instruction fetch queue between the IF stage and the ID-stage segment register. It replaces the single-entry IF/ID latch with a DEPTH-entry FIFO of {pc, inst} pairs. The FIFO uses valid/ready handshakes on both sides, a global enable, a redirect flush, and stops accepting input at a halt instruction. Fetch can therefore run ahead of decode, and a backpressured decode stalls fetch without dropping instructions.

---
 rtl/ifq_pkg.sv | 13 +
 rtl/ifq_ram.sv | 25 ++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: halt encoding, reset pc
// and the {pc, inst} entry layout.
package ifq_pkg;

    localparam logic [31:0] HALT_INST = 32'h8000_0000;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the fetch queue: one synchronous write port and one
// combinational read port. Contents are deliberately never reset.
module ifq_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry {pc, inst} FIFO between IF and ID with halt, flush and enable.
// Define IFQ_BYPASS_EN to let an empty queue forward in_* to out_* in the same cycle.
module fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [XLEN-1:0]          out_pcadd4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [2*XLEN-1:0] head;
    logic              bypass;
    logic              pass;
    logic              enq;
    logic              deq;
    logic              store;
    logic              pop;
    logic              is_halt;

`ifdef IFQ_BYPASS_EN
    assign bypass = en & ~halted & in_valid & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = en & ~halted & (count != FULL_CNT);
    assign out_valid = (en & (count != '0)) | bypass;

    assign enq     = in_valid & in_ready;
    assign deq     = out_valid & out_ready & en;
    // A bypassed entry that is consumed immediately never touches storage.
    assign pass    = bypass & out_ready;
    assign store   = enq & ~pass & ~flush;
    assign pop     = deq & ~pass;
    assign is_halt = (in_inst == XLEN'(HALT_INST));

    ifq_ram #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_comb begin
        out_pc     = '0;
        out_inst   = '0;
        out_pcadd4 = '0;
        if (out_valid) begin
            if (bypass) begin
                out_pc   = in_pc;
                out_inst = in_inst;
            end else begin
                out_pc   = head[2*XLEN-1:XLEN];
                out_inst = head[XLEN-1:0];
            end
            out_pcadd4 = out_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (store && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !store) begin
                count <= count - CW'(1);
            end
            if (enq && is_halt) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
    import ifq_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_inst;
    logic [XLEN-1:0]   out_pcadd4;
    logic [$clog2(DEPTH):0] count;
    logic              halted;

    int errors = 0;
    int checks = 0;

    ifq_entry_t m_q[$];
    bit         m_halted;
    bit         m_bypass_mode;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_pcadd4 (out_pcadd4),
        .count      (count),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        @(posedge clk);
        m_q.delete();
        m_halted = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at negedge, compare against the model, clock, then advance the model.
    task automatic cyc(input bit e, input bit f, input bit iv, input logic [31:0] p,
                       input logic [31:0] i, input bit ordy);
        bit         exp_ir, exp_ov, byp, do_enq, do_deq;
        ifq_entry_t exp_head, ent;
        en = e; flush = f; in_valid = iv; in_pc = p; in_inst = i; out_ready = ordy;
        #1;
        exp_ir = e && !m_halted && (m_q.size() < DEPTH);
        byp    = m_bypass_mode && e && !m_halted && iv && (m_q.size() == 0);
        exp_ov = (e && m_q.size() != 0) || byp;
        ent.pc = p; ent.inst = i;
        exp_head = '0;
        if (exp_ov) exp_head = byp ? ent : m_q[0];
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("out_pc", out_pc, exp_head.pc);
        chk("out_inst", out_inst, exp_head.inst);
        chk("out_pcadd4", out_pcadd4, exp_ov ? exp_head.pc + 32'd4 : 32'd0);
        chk("count", {29'b0, count}, m_q.size());
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        @(posedge clk);
        if (f) begin
            m_q.delete();
            m_halted = 0;
        end else begin
            do_enq = iv && exp_ir;
            do_deq = exp_ov && ordy;
            if (do_deq && !byp) void'(m_q.pop_front());
            if (do_enq && !(byp && do_deq)) m_q.push_back(ent);
            if (do_enq && i == HALT_INST) m_halted = 1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v;
        v = $urandom();
        if (v == HALT_INST) v = 32'h0000_0013;
        return v;
    endfunction

    initial begin
`ifdef IFQ_BYPASS_EN
        m_bypass_mode = 1;
`else
        m_bypass_mode = 0;
`endif
        reset_dut();
        chk("reset_count", {29'b0, count}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Fill then drain
        for (int k = 0; k < 4; k++) cyc(1, 0, 1, 32'(k * 4), rnd_inst(), 0);
        chk("fill_count", {29'b0, count}, 32'd4);
        chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
        cyc(1, 0, 1, 32'h100, rnd_inst(), 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_pc", out_pc, 32'(k * 4));
            chk("drain_pcadd4", out_pcadd4, 32'(k * 4 + 4));
            cyc(1, 0, 0, 32'h0, 32'h0, 1);
        end
        chk("drain_count", {29'b0, count}, 32'd0);

        // Steady enq+deq across pointer wrap
        cyc(1, 0, 1, 32'h1000, rnd_inst(), 0);
        for (int k = 1; k <= 10; k++) cyc(1, 0, 1, 32'h1000 + 32'(k * 4), rnd_inst(), 1);
        chk("wrap_count", {29'b0, count}, 32'd1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Flush with simultaneous traffic
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 32'h2000 + 32'(k * 4), rnd_inst(), 0);
        cyc(1, 1, 1, 32'h2ffc, rnd_inst(), 1);
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Halt
        cyc(1, 0, 1, 32'h3000, 32'h0010_0093, 0);
        cyc(1, 0, 1, 32'h3004, HALT_INST, 0);
        cyc(1, 0, 1, 32'h3008, rnd_inst(), 0);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_in_ready", {31'b0, in_ready}, 32'd0);
        cyc(1, 0, 1, 32'h3008, rnd_inst(), 1);
        cyc(1, 0, 1, 32'h3008, rnd_inst(), 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);
        cyc(1, 1, 0, 32'h0, 32'h0, 0);
        chk("unhalt_halted", {31'b0, halted}, 32'd0);
        chk("unhalt_in_ready", {31'b0, in_ready}, 32'd1);

        // Enable freeze
        cyc(1, 0, 1, 32'h4000, rnd_inst(), 0);
        cyc(1, 0, 1, 32'h4004, rnd_inst(), 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 32'h4008, rnd_inst(), 1);
        chk("freeze_count", {29'b0, count}, 32'd2);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Bypass / minimum latency on an empty queue
        en = 1; flush = 0; in_valid = 1; in_pc = 32'h40; in_inst = 32'h0000_0013; out_ready = 1;
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("byp_out_pc", out_pc, 32'h40);
`else
        chk("nobyp_out_valid", {31'b0, out_valid}, 32'd0);
`endif
        cyc(1, 0, 1, 32'h40, 32'h0000_0013, 1);
        cyc(1, 0, 0, 32'h0, 32'h0, 1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_dut();
            end else begin
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2) != 0, {$urandom_range(0, 32'h3fff), 2'b00},
                    ($urandom_range(0, 39) == 0) ? HALT_INST : rnd_inst(),
                    $urandom_range(0, 2) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
